// File: rtl/rpn_pkg.sv
// Shared types for the RPN ALU: opcodes, error codes and FSM states.
// Optional MUL opcode is enabled by defining RPN_ALU_MUL_EN.
package rpn_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_PUSH = 4'd1,
    OP_POP  = 4'd2,
    OP_DUP  = 4'd3,
    OP_SWAP = 4'd4,
    OP_ADD  = 4'd5,
    OP_SUB  = 4'd6,
    OP_AND  = 4'd7,
    OP_OR   = 4'd8,
    OP_XOR  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_UNDER   = 2'd1,
    ERR_OVER    = 2'd2,
    ERR_ILLEGAL = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_OP2  = 3'd2,
    ST_WB   = 3'd3,
    ST_WB2  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

endpackage

// File: rtl/rpn_alu_core.sv
// Combinational B-op-A datapath; result is 0 for non-ALU opcodes.
// Ports: op (4b opcode), a (top operand), b (second operand), result.
// MUL (opcode 10) is only built when RPN_ALU_MUL_EN is defined.
module rpn_alu_core
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD: result = b + a;
      OP_SUB: result = b - a;
      OP_AND: result = b & a;
      OP_OR:  result = b | a;
      OP_XOR: result = b ^ a;
`ifdef RPN_ALU_MUL_EN
      // Single WIDTHxWIDTH multiplier, low WIDTH bits kept.
      OP_MUL: result = b * a;
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_alu.sv
// RPN command sequencer driving an external LIFO; owns FSM and depth.
// Ports: clk, rst (sync, active-high), cmd_valid/ready/op/imm,
//   stk_push/pop/wdata/rdata, done, err, depth. Macro: RPN_ALU_MUL_EN.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_wdata,
  input  logic [WIDTH-1:0] stk_rdata,
  output logic             done,
  output logic [1:0]       err,
  output logic [DEPTH-1:0] depth
);

  localparam logic [DEPTH-1:0] FULL = '1;
  localparam logic [DEPTH-1:0] ONE  = DEPTH'(1);

  state_e           state;
  state_e           state_n;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       err_q;
  logic [DEPTH-1:0] cnt;
  logic [WIDTH-1:0] result;

  err_e code;
  logic two_op;

  rpn_alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result)
  );

  // Legality and stack-bound checks, evaluated against the current depth.
  always_comb begin
    code   = ERR_NONE;
    two_op = 1'b0;
    case (op_q)
      OP_NOP: code = ERR_NONE;
      OP_PUSH: begin
        if (cnt == FULL) code = ERR_OVER;
      end
      OP_POP: begin
        if (cnt == '0) code = ERR_UNDER;
      end
      OP_DUP: begin
        if (cnt == '0)
          code = ERR_UNDER;
        else if (cnt == FULL)
          code = ERR_OVER;
      end
      OP_SWAP, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_XOR: begin
        if (cnt <= ONE)
          code = ERR_UNDER;
        else
          two_op = 1'b1;
      end
`ifdef RPN_ALU_MUL_EN
      OP_MUL: begin
        if (cnt <= ONE)
          code = ERR_UNDER;
        else
          two_op = 1'b1;
      end
`endif
      default: code = ERR_ILLEGAL;
    endcase
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_wdata = '0;
    done      = 1'b0;
    err       = 2'd0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = ST_EXEC;
      end
      ST_EXEC: begin
        state_n = ST_RESP;
        if (code == ERR_NONE) begin
          if (two_op) begin
            stk_pop = 1'b1;
            state_n = ST_OP2;
          end else begin
            case (op_q)
              OP_PUSH: begin
                stk_push  = 1'b1;
                stk_wdata = imm_q;
              end
              OP_POP: stk_pop = 1'b1;
              OP_DUP: begin
                stk_push  = 1'b1;
                stk_wdata = stk_rdata;
              end
              default: stk_push = 1'b0;
            endcase
          end
        end
      end
      ST_OP2: begin
        stk_pop = 1'b1;
        state_n = ST_WB;
      end
      ST_WB: begin
        stk_push = 1'b1;
        if (op_q == OP_SWAP) begin
          stk_wdata = a_q;
          state_n   = ST_WB2;
        end else begin
          stk_wdata = result;
          state_n   = ST_RESP;
        end
      end
      ST_WB2: begin
        stk_push  = 1'b1;
        stk_wdata = b_q;
        state_n   = ST_RESP;
      end
      ST_RESP: begin
        done    = 1'b1;
        err     = err_q;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= '0;
      imm_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      err_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (cmd_valid && cmd_ready) begin
        op_q  <= cmd_op;
        imm_q <= cmd_imm;
      end
      if (state == ST_EXEC) begin
        err_q <= code;
        if (two_op) a_q <= stk_rdata;
      end
      if (state == ST_OP2) b_q <= stk_rdata;
      if (stk_push)
        cnt <= cnt + ONE;
      else if (stk_pop)
        cnt <= cnt - ONE;
    end
  end

  assign depth = cnt;

endmodule
